uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 34 +++
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Frame constants and receiver state encoding shared by the UART
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Purpose  : Two-flop synchronizer for an asynchronous single-bit input
// Revision : 1.0
// ============================================================================
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic ref_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 receiver timed by an external oversample enable
// Revision : 1.0
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                 ref_clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] c_tick_mid  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] c_tick_last = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] c_bit_last  = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  rx_state_t            r_state,     w_state;
  logic [TW-1:0]        r_tick_cnt,  w_tick_cnt;
  logic [BW-1:0]        r_bit_cnt,   w_bit_cnt;
  logic [DATA_BITS-1:0] r_shreg,     w_shreg;
  logic [DATA_BITS-1:0] r_out,       w_out;
  logic                 r_valid,     w_valid;
  logic                 r_frame_err, w_frame_err;

  uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
    .ref_clk (ref_clk),
    .reset   (reset),
    .d       (rx),
    .q       (w_rx_s)
  );

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_out       <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_tick_cnt  <= w_tick_cnt;
      r_bit_cnt   <= w_bit_cnt;
      r_shreg     <= w_shreg;
      r_out       <= w_out;
      r_valid     <= w_valid;
      r_frame_err <= w_frame_err;
    end
  end

  // Every decision waits for a sample_tick; between ticks everything holds.
  always_comb begin
    w_state     = r_state;
    w_tick_cnt  = r_tick_cnt;
    w_bit_cnt   = r_bit_cnt;
    w_shreg     = r_shreg;
    w_out       = r_out;
    w_valid     = 1'b0;
    w_frame_err = 1'b0;
    if (sample_tick) begin
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            w_state    = START;
            w_tick_cnt = '0;
          end
        end
        START: begin
          if (r_tick_cnt == c_tick_mid) begin
            w_tick_cnt = '0;
            if (w_rx_s) begin
              w_state = IDLE;
            end else begin
              w_state   = DATA;
              w_bit_cnt = '0;
            end
          end else begin
            w_tick_cnt = r_tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_tick_cnt == c_tick_last) begin
            w_tick_cnt = '0;
            w_shreg    = {w_rx_s, r_shreg[DATA_BITS-1:1]};
            w_bit_cnt  = r_bit_cnt + 1'b1;
            if (r_bit_cnt == c_bit_last) begin
              w_state = STOP;
            end
          end else begin
            w_tick_cnt = r_tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_tick_cnt == c_tick_last) begin
            w_tick_cnt = '0;
            if (w_rx_s) begin
              w_out   = r_shreg;
              w_valid = 1'b1;
              w_state = IDLE;
            end else begin
              w_frame_err = 1'b1;
              w_state     = BREAK;
            end
          end else begin
            w_tick_cnt = r_tick_cnt + 1'b1;
          end
        end
        BREAK: begin
          // A held-low line must return high before another start is accepted.
          if (w_rx_s) begin
            w_state = IDLE;
          end
        end
        default: begin
          w_state = IDLE;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx (OVERSAMPLE = 16)
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

  localparam int BIT_NS = 640;  // 16 ticks x 4 clocks x 10 ns
  localparam int FAST_NS = 621; // -3 %
  localparam int SLOW_NS = 659; // +3 %

  logic       ref_clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       rx;
  logic [7:0] out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got[$];
  int         n_ferr    = 0;
  int         n_overlap = 0;
  int         n_wide    = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .ref_clk     (ref_clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .out         (out),
    .valid       (valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 ref_clk = ~ref_clk;

  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(posedge ref_clk);
      #1 sample_tick = 1'b1;
      @(posedge ref_clk);
      #1 sample_tick = 1'b0;
    end
  end

  always @(negedge ref_clk) begin
    if (valid) got.push_back(out);
    if (frame_err) n_ferr++;
    if (valid && frame_err) n_overlap++;
    if ((valid && prev_valid) || (frame_err && prev_ferr)) n_wide++;
    prev_valid <= valid;
    prev_ferr  <= frame_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic expect_bytes(input string tag, input logic [7:0] exp[$]);
    check_eq({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check_eq(tag, (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD, {24'h0, exp[i]});
    end
    got.delete();
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] partial;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(posedge ref_clk);
    @(negedge ref_clk);
    check_eq("rst_out", out, 8'h00);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_ferr", frame_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    @(posedge ref_clk);
    #1 reset = 1'b0;
    #(2 * BIT_NS);

    // Good frame at exact baud
    send_frame(8'hA5, 1'b1, BIT_NS);
    #(BIT_NS);
    exp_q = '{8'hA5};
    expect_bytes("good_a5", exp_q);
    check_eq("good_ferr", n_ferr, 0);
    check_eq("good_busy", busy, 1'b0);

    // Short low glitch on an idle line
    rx = 1'b0;
    #(BIT_NS / 4);
    rx = 1'b1;
    #(2 * BIT_NS);
    check_eq("glitch_valid", got.size(), 0);
    check_eq("glitch_ferr", n_ferr, 0);
    check_eq("glitch_out", out, 8'hA5);
    check_eq("glitch_busy", busy, 1'b0);

    // Framing error followed by a long break, then recovery
    send_frame(8'h3C, 1'b0, BIT_NS);
    #(5 * BIT_NS);
    check_eq("ferr_pulse", n_ferr, 1);
    check_eq("ferr_busy_break", busy, 1'b1);
    check_eq("ferr_out_kept", out, 8'hA5);
    #(25 * BIT_NS);
    check_eq("break_ferr", n_ferr, 1);
    check_eq("break_valid", got.size(), 0);
    rx = 1'b1;
    #(2 * BIT_NS);
    check_eq("break_idle", busy, 1'b0);
    send_frame(8'h81, 1'b1, BIT_NS);
    #(BIT_NS);
    exp_q = '{8'h81};
    expect_bytes("after_break", exp_q);
    check_eq("after_break_ferr", n_ferr, 1);

    // Back-to-back frames with baud error in both directions
    send_frame(8'h00, 1'b1, SLOW_NS);
    send_frame(8'hFF, 1'b1, SLOW_NS);
    send_frame(8'h55, 1'b1, SLOW_NS);
    send_frame(8'h00, 1'b1, FAST_NS);
    send_frame(8'hFF, 1'b1, FAST_NS);
    send_frame(8'h55, 1'b1, FAST_NS);
    rx = 1'b1;
    #(2 * BIT_NS);
    exp_q = '{8'h00, 8'hFF, 8'h55, 8'h00, 8'hFF, 8'h55};
    expect_bytes("b2b", exp_q);
    check_eq("b2b_ferr", n_ferr, 1);

    // Reset during data bit 4 of 0x12
    partial = 8'h12;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      #(BIT_NS);
    end
    rx = partial[4];
    #(BIT_NS / 2);
    @(posedge ref_clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge ref_clk);
    @(negedge ref_clk);
    check_eq("midrst_out", out, 8'h00);
    check_eq("midrst_valid", valid, 1'b0);
    check_eq("midrst_ferr", frame_err, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    @(posedge ref_clk);
    #1 reset = 1'b0;
    rx = 1'b1;
    #(2 * BIT_NS);
    check_eq("midrst_nopulse", got.size(), 0);
    send_frame(8'h34, 1'b1, BIT_NS);
    #(BIT_NS);
    exp_q = '{8'h34};
    expect_bytes("midrst_34", exp_q);
    check_eq("midrst_ferr_total", n_ferr, 1);

    // Loopback-style sweep across the byte range
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(i * 17), 1'b1, BIT_NS);
      exp_q.push_back(8'(i * 17));
    end
    rx = 1'b1;
    #(2 * BIT_NS);
    expect_bytes("sweep", exp_q);

    check_eq("pulse_overlap", n_overlap, 0);
    check_eq("pulse_width", n_wide, 0);
    check_eq("final_ferr", n_ferr, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
